tsmp_cmd_parser: RTL and testbench

Sits directly downstream of the TSMP classifier on its PLC-side output (wv_data_pip2plc / w_data_wr_pip2plc).
- Consumes complete TSMP read/write frames as a 9-bit byte stream. Bit 8 flags the first and last byte of a frame.
- Extracts command type, 32-bit register address and 32-bit write data.
- Issues a single register-access request to the PLC register bank over a req/ack handshake.
- Counts malformed frames and frames dropped while a request is outstanding.

---
 rtl/tsmp_pkg.sv | 31 +++
 rtl/tsmp_cmd_parser_if.sv | 24 ++
 rtl/sat_counter.sv | 21 ++
 rtl/tsmp_cmd_parser.sv | 131 +++++++++++++
 tb/tb_tsmp_cmd_parser.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tsmp_pkg.sv
// Shared TSMP definitions: frame type codes, field byte offsets and the
// command-parser state encoding.
package tsmp_pkg;

  localparam logic [7:0] TSMP_TYPE_READ   = 8'h00;
  localparam logic [7:0] TSMP_TYPE_WRITE  = 8'h01;
  localparam logic [7:0] TSMP_TYPE_CONFIG = 8'h16;
  localparam logic [7:0] TSMP_TYPE_NONE   = 8'hff;

  localparam int unsigned HEAD_LEN    = 14;
  localparam int unsigned TYPE_OFF    = HEAD_LEN;
  localparam int unsigned ADDR_OFF    = HEAD_LEN + 1;
  localparam int unsigned ADDR_BYTES  = 4;
  localparam int unsigned WDATA_OFF   = ADDR_OFF + ADDR_BYTES;
  localparam int unsigned WDATA_BYTES = 4;

  // Shortest legal frames: the tail byte may itself carry the last field byte
  localparam int unsigned READ_MIN_TAIL  = ADDR_OFF + ADDR_BYTES - 1;
  localparam int unsigned WRITE_MIN_TAIL = WDATA_OFF + WDATA_BYTES - 1;

  localparam int unsigned IDX_WIDTH = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_FIELD,
    ST_ISSUE,
    ST_DROP
  } state_t;

endpackage

// File: rtl/tsmp_cmd_parser_if.sv
// Byte-stream input and register-request output of the TSMP command parser.
interface tsmp_cmd_parser_if #(
  parameter int unsigned DATA_WIDTH  = 9,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WDATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]  iv_data;
  logic                   i_data_wr;
  logic                   o_rd_req;
  logic                   o_wr_req;
  logic [ADDR_WIDTH-1:0]  ov_addr;
  logic [WDATA_WIDTH-1:0] ov_wdata;
  logic                   i_ack;

  modport master (
    output iv_data, i_data_wr, i_ack,
    input  o_rd_req, o_wr_req, ov_addr, ov_wdata
  );

  modport slave (
    input  iv_data, i_data_wr, i_ack,
    output o_rd_req, o_wr_req, ov_addr, ov_wdata
  );
endinterface

// File: rtl/sat_counter.sv
// Counter that increments on a pulse and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] ov_cnt
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign ov_cnt = r_cnt;
endmodule

// File: rtl/tsmp_cmd_parser.sv
// Parses TSMP read/write frames from the PLC-side byte stream and issues one
// register request per valid frame; frames arriving while busy are dropped.
module tsmp_cmd_parser
  import tsmp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 9,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WDATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  tsmp_cmd_parser_if.slave     bus,
  output logic [CNT_WIDTH-1:0] ov_err_cnt,
  output logic [CNT_WIDTH-1:0] ov_drop_cnt
);
  state_t                 r_state;
  logic [IDX_WIDTH-1:0]   r_k;
  logic [7:0]             r_type;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [WDATA_WIDTH-1:0] r_wdata;
  logic                   r_rd_req;
  logic                   r_wr_req;
  logic                   r_drop_open;

  logic       w_acc, w_flag, w_in_frame, w_tail;
  logic       w_in_type, w_in_addr, w_in_wdata;
  logic       w_rd_ok, w_wr_ok, w_err_inc;
  logic       w_drop_head, w_drop_close, w_drop_open_nxt;
  logic [7:0] w_byte;

  assign w_acc      = bus.i_data_wr;
  assign w_flag     = bus.iv_data[DATA_WIDTH-1];
  assign w_byte     = bus.iv_data[7:0];
  assign w_in_frame = (r_state == ST_HEAD) || (r_state == ST_FIELD);
  assign w_tail     = w_in_frame && w_acc && w_flag;

  assign w_in_type  = (r_k == IDX_WIDTH'(TYPE_OFF));
  assign w_in_addr  = (r_k >= IDX_WIDTH'(ADDR_OFF)) && (r_k < IDX_WIDTH'(ADDR_OFF + ADDR_BYTES));
  assign w_in_wdata = (r_k >= IDX_WIDTH'(WDATA_OFF)) && (r_k < IDX_WIDTH'(WDATA_OFF + WDATA_BYTES));

  assign w_rd_ok   = (r_type == TSMP_TYPE_READ)  && (r_k >= IDX_WIDTH'(READ_MIN_TAIL));
  assign w_wr_ok   = (r_type == TSMP_TYPE_WRITE) && (r_k >= IDX_WIDTH'(WRITE_MIN_TAIL));
  assign w_err_inc = w_tail && !(w_rd_ok || w_wr_ok);

  // While busy, flagged bytes alternate between opening and closing a drop
  assign w_drop_head     = (r_state == ST_ISSUE) && w_acc && w_flag && !r_drop_open;
  assign w_drop_close    = (r_state == ST_ISSUE) && w_acc && w_flag &&  r_drop_open;
  assign w_drop_open_nxt = w_drop_head || (r_drop_open && !w_drop_close);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_type      <= TSMP_TYPE_NONE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_req    <= 1'b0;
      r_wr_req    <= 1'b0;
      r_drop_open <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc && w_flag) begin
            r_state <= ST_HEAD;
            r_k     <= IDX_WIDTH'(1);
            r_type  <= TSMP_TYPE_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
          end
        end
        ST_HEAD, ST_FIELD: begin
          if (w_acc) begin
            if (w_in_type)  r_type  <= w_byte;
            if (w_in_addr)  r_addr  <= {r_addr[ADDR_WIDTH-9:0], w_byte};
            if (w_in_wdata) r_wdata <= {r_wdata[WDATA_WIDTH-9:0], w_byte};
            if (r_k != '1)  r_k     <= r_k + IDX_WIDTH'(1);
            if (w_flag) begin
              if (w_rd_ok || w_wr_ok) begin
                r_state     <= ST_ISSUE;
                r_rd_req    <= w_rd_ok;
                r_wr_req    <= w_wr_ok;
                r_drop_open <= 1'b0;
                // Reads carry no data even if pad bytes landed in the data slot
                if (w_rd_ok) r_wdata <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else if (r_k >= IDX_WIDTH'(HEAD_LEN - 1)) begin
              r_state <= ST_FIELD;
            end
          end
        end
        ST_ISSUE: begin
          r_drop_open <= w_drop_open_nxt;
          if (bus.i_ack) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_state  <= w_drop_open_nxt ? ST_DROP : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (w_acc && w_flag) begin
            r_state     <= ST_IDLE;
            r_drop_open <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_rd_req = r_rd_req;
  assign bus.o_wr_req = r_wr_req;
  assign bus.ov_addr  = r_addr;
  assign bus.ov_wdata = r_wdata;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_err_inc),
    .ov_cnt (ov_err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_drop_head),
    .ov_cnt (ov_drop_cnt)
  );
endmodule

// File: tb/tb_tsmp_cmd_parser.sv
// Directed bench for tsmp_cmd_parser: a table of single-frame vectors plus
// hand-written busy-drop, saturation and reset sequences.
module tb_tsmp_cmd_parser;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  tsmp_cmd_parser_if bus ();

  tsmp_cmd_parser dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus.slave),
    .ov_err_cnt  (err_cnt),
    .ov_drop_cnt (drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int exp_drop = 0;

  logic [7:0] fr [0:63];
  int         fr_len;

  typedef struct {
    logic [7:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
    bit          gaps;
    bit          exp_rd;
    bit          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build(input logic [7:0] typ, input logic [31:0] a, input logic [31:0] d, input int len);
    for (int k = 0; k < len; k++) begin
      if (k < 14)       fr[k] = 8'(8'h10 + k);
      else if (k == 14) fr[k] = typ;
      else if (k < 19)  fr[k] = a[8*(18-k) +: 8];
      else if (k < 23)  fr[k] = d[8*(22-k) +: 8];
      else              fr[k] = 8'h77;
    end
    fr_len = len;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic flag, input logic [7:0] b);
    bus.iv_data   = {flag, b};
    bus.i_data_wr = 1'b1;
    @(posedge clk);
    #1;
    bus.i_data_wr = 1'b0;
    bus.iv_data   = '0;
  endtask

  task automatic send_part(input int lo, input int hi, input bit gaps);
    for (int k = lo; k <= hi; k++) begin
      send_byte((k == 0) || (k == fr_len - 1), fr[k]);
      if (gaps && k != fr_len - 1) idle(1 + (k % 3));
    end
  endtask

  task automatic ack_req(input int wait_cyc);
    idle(wait_cyc);
    bus.i_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ack = 1'b0;
  endtask

  // Read and write requests must never overlap
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (bus.o_rd_req === 1'b1 && bus.o_wr_req === 1'b1) begin
        errors++;
        $display("FAIL rd_wr_exclusive: got rd=1 wr=1 expected not both");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h01, 32'h0000_1234, 32'hDEAD_BEEF, 24, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{8'h00, 32'hA000_0004, 32'hFFFF_FFFF, 22, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{8'h01, 32'h0000_5678, 32'h1111_2222, 21, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{8'h16, 32'h0000_5678, 32'h1111_2222, 24, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{8'h00, 32'h1122_3344, 32'h0,         19, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{8'h01, 32'h8765_4321, 32'hCAFE_F00D, 23, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[6] = '{8'h00, 32'h1122_3344, 32'h0,         18, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{8'h02, 32'h0000_0010, 32'h0000_0020, 24, 1'b0, 1'b0, 1'b0, 32'h0};

    rst           = 1'b1;
    bus.iv_data   = '0;
    bus.i_data_wr = 1'b0;
    bus.i_ack     = 1'b0;
    idle(3);
    check("reset_rd",    64'(bus.o_rd_req), 64'd0);
    check("reset_wr",    64'(bus.o_wr_req), 64'd0);
    check("reset_addr",  64'(bus.ov_addr),  64'd0);
    check("reset_wdata", 64'(bus.ov_wdata), 64'd0);
    check("reset_err",   64'(err_cnt),      64'd0);
    check("reset_drop",  64'(drop_cnt),     64'd0);
    rst = 1'b0;
    idle(2);

    // Single-frame vectors
    for (int i = 0; i < 8; i++) begin
      build(vecs[i].typ, vecs[i].addr, vecs[i].data, vecs[i].len);
      send_part(0, fr_len - 1, vecs[i].gaps);
      if (vecs[i].exp_rd || vecs[i].exp_wr) begin
        check($sformatf("v%0d_rd", i),    64'(bus.o_rd_req), 64'(vecs[i].exp_rd));
        check($sformatf("v%0d_wr", i),    64'(bus.o_wr_req), 64'(vecs[i].exp_wr));
        check($sformatf("v%0d_addr", i),  64'(bus.ov_addr),  64'(vecs[i].addr));
        check($sformatf("v%0d_wdata", i), 64'(bus.ov_wdata), 64'(vecs[i].exp_wdata));
        idle(3);
        check($sformatf("v%0d_held", i),  64'(bus.o_rd_req | bus.o_wr_req), 64'd1);
        ack_req(0);
        check($sformatf("v%0d_rel", i),   64'(bus.o_rd_req | bus.o_wr_req), 64'd0);
      end else begin
        exp_err++;
        check($sformatf("v%0d_noreq", i), 64'(bus.o_rd_req | bus.o_wr_req), 64'd0);
      end
      check($sformatf("v%0d_err", i), 64'(err_cnt), 64'(exp_err));
      idle(2);
      check($sformatf("v%0d_quiet", i), 64'(bus.o_rd_req | bus.o_wr_req), 64'd0);
    end

    // Back-to-back frame while the first request is outstanding
    build(8'h01, 32'h0000_1234, 32'h0102_0304, 24);
    send_part(0, fr_len - 1, 1'b0);
    check("b2b_wr", 64'(bus.o_wr_req), 64'd1);
    build(8'h01, 32'h0000_5555, 32'h0A0B_0C0D, 24);
    send_part(0, fr_len - 1, 1'b0);
    exp_drop++;
    idle(16);
    check("b2b_drop",  64'(drop_cnt),     64'(exp_drop));
    check("b2b_held",  64'(bus.o_wr_req), 64'd1);
    check("b2b_nord",  64'(bus.o_rd_req), 64'd0);
    check("b2b_addr",  64'(bus.ov_addr),  64'h0000_1234);
    check("b2b_wdata", 64'(bus.ov_wdata), 64'h0102_0304);
    ack_req(0);
    check("b2b_rel", 64'(bus.o_wr_req), 64'd0);
    build(8'h00, 32'hBEEF_0000, 32'h0, 20);
    send_part(0, fr_len - 1, 1'b0);
    check("b2b_third_rd",   64'(bus.o_rd_req), 64'd1);
    check("b2b_third_addr", 64'(bus.ov_addr),  64'hBEEF_0000);
    ack_req(1);

    // Head arriving in the same cycle as the ack
    build(8'h01, 32'h0C0C_0C0C, 32'h5A5A_5A5A, 24);
    send_part(0, fr_len - 1, 1'b0);
    check("ackhd_wr", 64'(bus.o_wr_req), 64'd1);
    build(8'h00, 32'h0000_0099, 32'h0, 24);
    bus.i_ack     = 1'b1;
    bus.iv_data   = {1'b1, fr[0]};
    bus.i_data_wr = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ack     = 1'b0;
    bus.i_data_wr = 1'b0;
    exp_drop++;
    check("ackhd_drop", 64'(drop_cnt), 64'(exp_drop));
    check("ackhd_rel",  64'(bus.o_wr_req | bus.o_rd_req), 64'd0);
    send_part(1, fr_len - 1, 1'b0);
    check("ackhd_noreq", 64'(bus.o_wr_req | bus.o_rd_req), 64'd0);
    check("ackhd_noerr", 64'(err_cnt), 64'(exp_err));
    build(8'h00, 32'h0000_ABCD, 32'h0, 19);
    send_part(0, fr_len - 1, 1'b0);
    check("ackhd_next_rd",   64'(bus.o_rd_req), 64'd1);
    check("ackhd_next_addr", 64'(bus.ov_addr),  64'h0000_ABCD);
    check("ackhd_next_drop", 64'(drop_cnt),     64'(exp_drop));
    ack_req(0);

    // Error counter saturation
    force dut.u_err_cnt.r_cnt = 16'hFFFE;
    #1;
    release dut.u_err_cnt.r_cnt;
    build(8'h16, 32'h0, 32'h0, 24);
    send_part(0, fr_len - 1, 1'b0);
    check("sat_reach", 64'(err_cnt), 64'hFFFF);
    send_part(0, fr_len - 1, 1'b0);
    check("sat_hold", 64'(err_cnt), 64'hFFFF);
    check("sat_noreq", 64'(bus.o_wr_req | bus.o_rd_req), 64'd0);

    // Reset while a request is outstanding
    build(8'h01, 32'h0000_7777, 32'h0000_8888, 24);
    send_part(0, fr_len - 1, 1'b0);
    check("rstreq_wr", 64'(bus.o_wr_req), 64'd1);
    rst = 1'b1;
    #1;
    check("rstreq_wr0", 64'(bus.o_wr_req), 64'd0);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Reset mid-frame, then a clean frame
    build(8'h01, 32'h0000_4444, 32'h0000_5555, 24);
    send_part(0, 15, 1'b0);
    rst = 1'b1;
    #1;
    check("rstmid_rd",    64'(bus.o_rd_req), 64'd0);
    check("rstmid_wr",    64'(bus.o_wr_req), 64'd0);
    check("rstmid_addr",  64'(bus.ov_addr),  64'd0);
    check("rstmid_wdata", 64'(bus.ov_wdata), 64'd0);
    check("rstmid_err",   64'(err_cnt),      64'd0);
    check("rstmid_drop",  64'(drop_cnt),     64'd0);
    idle(1);
    rst = 1'b0;
    idle(1);
    build(8'h01, 32'h00C0_FFEE, 32'h1234_5678, 24);
    send_part(0, fr_len - 1, 1'b0);
    check("post_rst_wr",    64'(bus.o_wr_req), 64'd1);
    check("post_rst_addr",  64'(bus.ov_addr),  64'h00C0_FFEE);
    check("post_rst_wdata", 64'(bus.ov_wdata), 64'h1234_5678);
    check("post_rst_err",   64'(err_cnt),      64'd0);
    ack_req(2);
    check("post_rst_rel", 64'(bus.o_wr_req), 64'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
